// File: rtl/local_mem_amo_responder_pkg.sv
// Shared types for the local scratchpad responder: request/AMO descriptors,
// AMO funct5 encodings and the responder FSM state.
package local_mem_amo_responder_pkg;

    localparam int ID_W      = 4;
    localparam int SUBUNIT_W = 2;

    typedef logic [ID_W-1:0] id_t;

    localparam logic [4:0] AMO_ADD_FN5  = 5'b00000;
    localparam logic [4:0] AMO_SWAP_FN5 = 5'b00001;
    localparam logic [4:0] AMO_LR_FN5   = 5'b00010;
    localparam logic [4:0] AMO_SC_FN5   = 5'b00011;
    localparam logic [4:0] AMO_XOR_FN5  = 5'b00100;
    localparam logic [4:0] AMO_OR_FN5   = 5'b01000;
    localparam logic [4:0] AMO_AND_FN5  = 5'b01100;
    localparam logic [4:0] AMO_MIN_FN5  = 5'b10000;
    localparam logic [4:0] AMO_MAX_FN5  = 5'b10100;
    localparam logic [4:0] AMO_MINU_FN5 = 5'b11000;
    localparam logic [4:0] AMO_MAXU_FN5 = 5'b11100;

    typedef struct packed {
        logic       aq;
        logic       rl;
        logic       is_lr;
        logic       is_sc;
        logic       is_rmw;
        logic [4:0] op;
    } amo_details_t;

    typedef struct packed {
        logic [31:0]          addr;
        logic                 load;
        logic                 store;
        logic [3:0]           be;
        logic [2:0]           fn3;
        logic [31:0]          data_in;
        id_t                  id;
        logic [SUBUNIT_W-1:0] subunit_id;
        amo_details_t         amo;
    } data_access_shared_inputs_t;

    typedef struct packed {
        logic [31:0] rs1_load;
        logic [31:0] rs2;
        logic [4:0]  op;
    } amo_alu_inputs_t;

    typedef enum logic {
        IDLE,
        RMW_WRITE
    } local_mem_state_t;

endpackage

// File: rtl/local_mem_amo_responder_amo_alu.sv
// Read-modify-write AMO datapath: combines the old memory word with the
// request operand according to the AMO funct5.
module amo_alu
    import local_mem_amo_responder_pkg::*;
(
    input  amo_alu_inputs_t alu_in,
    output logic [31:0]     result
);

    logic [31:0] a;
    logic [31:0] b;

    assign a = alu_in.rs1_load;
    assign b = alu_in.rs2;

    always_comb begin
        result = b;
        case (alu_in.op)
            AMO_ADD_FN5:  result = a + b;
            AMO_SWAP_FN5: result = b;
            AMO_XOR_FN5:  result = a ^ b;
            AMO_OR_FN5:   result = a | b;
            AMO_AND_FN5:  result = a & b;
            AMO_MIN_FN5:  result = ($signed(a) < $signed(b)) ? a : b;
            AMO_MAX_FN5:  result = ($signed(a) > $signed(b)) ? a : b;
            AMO_MINU_FN5: result = (a < b) ? a : b;
            AMO_MAXU_FN5: result = (a > b) ? a : b;
            default:      result = b;
        endcase
    end

endmodule

// File: rtl/local_mem_amo_responder.sv
// Single-cycle scratchpad responder: loads, byte-masked stores, LR/SC with a
// single-hart reservation, and two-cycle RMW AMOs over a single-port word RAM.
module local_mem_amo_responder
    import local_mem_amo_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       new_request,
    input  data_access_shared_inputs_t req,
    output logic                       ready,
    output logic                       data_valid,
    output logic [31:0]                data_out,
    output id_t                        rsp_id,
    output logic                       reservation_valid
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    local_mem_state_t state;
    local_mem_state_t next_state;

    logic             accept;
    logic             is_sc, is_rmw, is_lr, is_load, is_store;
    logic [IDX_W-1:0] req_idx, rmw_idx, resv_idx, ram_idx;
    logic             resv_match;
    logic [31:0]      rmw_data, alu_result, ram_rd, ram_wdata;
    logic [4:0]       rmw_op;
    logic [3:0]       ram_we;
    logic             ram_en;
    logic             rsp_is_sc, sc_fail;
    logic [31:0]      mem [DEPTH_WORDS];

    // Address bits outside the word index and informational fields are not used here.
    logic unused_bits;
    assign unused_bits = ^{req.addr[31:IDX_W+2], req.addr[1:0], req.fn3,
                           req.subunit_id, req.amo.aq, req.amo.rl, BASE_ADDR};

    assign req_idx    = req.addr[IDX_W+1:2];
    assign accept     = new_request && ready;
    assign resv_match = reservation_valid && (resv_idx == req_idx);

    always_comb begin
        is_sc    = req.amo.is_sc;
        is_rmw   = !req.amo.is_sc && req.amo.is_rmw;
        is_lr    = !req.amo.is_sc && !req.amo.is_rmw && req.amo.is_lr;
        is_load  = !req.amo.is_sc && !req.amo.is_rmw && !req.amo.is_lr && req.load;
        is_store = !req.amo.is_sc && !req.amo.is_rmw && !req.amo.is_lr && !req.load && req.store;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (accept && is_rmw) next_state = RMW_WRITE;
            RMW_WRITE: next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE) && !rst;
    end

    // The single RAM port is owned by the pending RMW write-back while in RMW_WRITE.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'h0;
        ram_idx   = req_idx;
        ram_wdata = req.data_in;
        if (state == RMW_WRITE) begin
            ram_idx   = rmw_idx;
            ram_wdata = alu_result;
            ram_en    = !rst;
            ram_we    = rst ? 4'h0 : 4'hF;
        end else if (accept) begin
            ram_en = 1'b1;
            if (is_store)                ram_we = req.be;
            else if (is_sc && resv_match) ram_we = 4'hF;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rd <= mem[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reservation_valid <= 1'b0;
            resv_idx          <= '0;
        end else if (accept) begin
            if (is_lr) begin
                reservation_valid <= 1'b1;
                resv_idx          <= req_idx;
            end else if (is_sc) begin
                reservation_valid <= 1'b0;
            end else if ((is_store || is_rmw) && resv_match) begin
                reservation_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid <= 1'b0;
            rsp_id     <= '0;
            rsp_is_sc  <= 1'b0;
            sc_fail    <= 1'b0;
        end else begin
            data_valid <= accept && (is_sc || is_rmw || is_lr || is_load);
            if (accept) begin
                rsp_id    <= req.id;
                rsp_is_sc <= is_sc;
                sc_fail   <= !resv_match;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && is_rmw) begin
            rmw_idx  <= req_idx;
            rmw_data <= req.data_in;
            rmw_op   <= req.amo.op;
        end
    end

    always_comb begin
        if (!data_valid)    data_out = '0;
        else if (rsp_is_sc) data_out = {31'b0, sc_fail};
        else                data_out = ram_rd;
    end

    amo_alu u_amo_alu (
        .alu_in ('{rs1_load: ram_rd, rs2: rmw_data, op: rmw_op}),
        .result (alu_result)
    );

endmodule
